// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter, LSB first, for the md5 host link.
// Define UART_TX_PARITY_EN to insert an even-parity bit between d7 and stop.
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 833
) (
  input  logic       clk_96mhz,
  input  logic       reset,
  input  logic [7:0] txd_data,
  input  logic       txd_start,
  output logic       txd_busy,
  output logic       txd_done,
  output logic       txd
);

  localparam logic [15:0] LP_MAX = 16'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP
  } state_t;
`endif

  state_t      r_state;
  logic [15:0] r_cnt;
  logic [2:0]  r_idx;
  logic [7:0]  r_shift;
  logic        r_txd;
  logic        r_busy;
  logic        r_done;
  logic        w_bit_end;
`ifdef UART_TX_PARITY_EN
  logic        r_par;
`endif

  assign w_bit_end = (r_cnt == LP_MAX);
  assign txd       = r_txd;
  assign txd_busy  = r_busy;
  assign txd_done  = r_done;

  always_ff @(posedge clk_96mhz) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_txd   <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (txd_start) begin
            r_shift <= txd_data;
            r_cnt   <= '0;
            r_txd   <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_START;
`ifdef UART_TX_PARITY_EN
            r_par   <= ^txd_data;
`endif
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_txd   <= r_shift[0];
            r_state <= S_DATA;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_shift <= r_shift >> 1;
            r_idx   <= r_idx + 3'd1;
            if (r_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              r_txd   <= r_par;
              r_state <= S_PARITY;
`else
              r_txd   <= 1'b1;
              r_state <= S_STOP;
`endif
            end else begin
              // next data bit is the one about to shift into bit 0
              r_txd <= r_shift[1];
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_txd   <= 1'b1;
            r_state <= S_STOP;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
`endif
        S_STOP: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: begin
          r_cnt   <= '0;
          r_txd   <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter for the host link of the md5 engine. Accepts one byte at a time from the command parser over the `txd_data`/`txd_start`/`txd_busy` handshake and shifts it out on the UART TX pin. The frame is 8N1, LSB first, with an optional even-parity bit. It is the return path paired with the UART receiver that feeds `rxd_data`/`rxd_data_ready` into the command parser. ACK/NACK bytes and result bytes leave the FPGA through this block.

## Interface
- `CLKS_PER_BIT`, default 833: clock cycles per bit period (96 MHz / 115200 baud). Legal range is 2..65535.
- `clk_96mhz`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `txd_data`  in  8  byte to send; sampled only on the accept cycle.
- `txd_start`  in  1  send request; a level, sampled every cycle.
- `txd_busy`  out  1  high while a frame is in progress; registered.
- `txd_done`  out  1  one-cycle pulse at the end of the stop bit; registered.
- `txd`  out  1  serial line; idles high; registered.

## Operation
- States: IDLE, START, DATA, PARITY (only with the macro), STOP. `txd_busy` = (state != IDLE), driven from a register.
- Accept rule: a request is accepted on a clock edge where state == IDLE and `txd_start` == 1.
  - On that edge, `txd_data` is latched into the shift register, state becomes START, `txd` goes 0, `txd_busy` goes 1.
- `txd_start` seen while busy is ignored. It is not queued.
- Baud counter: 16 bits. Cleared on accept and on every bit boundary. The state advances when the counter reaches `CLKS_PER_BIT-1`.
- START: drives 0 for one bit period, then goes to DATA with bit index 0.
- DATA: drives `shift[0]`. At each bit boundary the register shifts right and the 3-bit bit index increments. After index 7 completes, goes to PARITY or STOP.
- PARITY: drives the XOR of the latched byte for one bit period (even parity), then goes to STOP.
- STOP: drives 1 for one bit period.
  - On its final cycle: state becomes IDLE, `txd_done` pulses for one cycle, `txd_busy` falls.
- Back-to-back sends: if `txd_start` is held high, the next request is accepted on the first IDLE cycle. This gives one extra idle-high cycle between frames.
- Changes on `txd_data` after the accept edge have no effect on the frame in flight.
- Reset, at any point including mid-frame, takes effect on the next edge:
  - state IDLE, `txd` = 1, `txd_busy` = 0, `txd_done` = 0;
  - baud counter, bit index and shift register all cleared.
  - A partial frame is abandoned, not completed.

## Timing
- Reset values: `txd` 1, `txd_busy` 0, `txd_done` 0.
- Start-to-line latency: `txd` falls, and `txd_busy` rises, on the same edge that samples `txd_start`. Both are visible one cycle after the request cycle.
- Every bit, including start, parity and stop, lasts exactly `CLKS_PER_BIT` cycles.
- `txd_busy` stays high for exactly 10×`CLKS_PER_BIT` cycles, or 11×`CLKS_PER_BIT` with parity.
- `txd_done` is asserted on the cycle `txd_busy` first reads 0.
- Minimum accept-to-accept spacing is 10×`CLKS_PER_BIT`+1 cycles (11×`CLKS_PER_BIT`+1 with parity).
- Bit order on the line: start, d0, d1, ..., d7, [parity], stop.

## Configuration
- `UART_TX_PARITY_EN`
  - Defined: the PARITY state is compiled in and an even-parity bit is inserted between d7 and stop. The frame is 11 bit periods.
  - Undefined: the PARITY state and XOR logic are absent, and DATA goes directly to STOP. The frame is 10 bit periods (8N1).

## Test plan
All scenarios use `CLKS_PER_BIT`=8.

1. Reset, then idle:
   - Stimulus: reset held 3 cycles, then released with no request.
   - Required: `txd`=1, `txd_busy`=0, `txd_done`=0 on every cycle.
2. Single send of 0x01, `txd_start` high for 1 cycle:
   - Required line, each level held 8 cycles: 0, 1, 0, 0, 0, 0, 0, 0, 0, 1.
   - Required: `txd_busy` high for exactly 80 cycles; `txd_done` pulses once on cycle 81.
3. Ignore while busy:
   - Stimulus: send 0xA5; pulse `txd_start` with 0xFF at cycle 20.
   - Required: exactly one frame, carrying 0xA5. `txd_data` changes after accept do not alter the frame.
4. Back-to-back:
   - Stimulus: `txd_start` held high; `txd_data`=0x55, switched to 0xA3 during the first frame.
   - Required: frames 0x55 then 0xA3, with second start bit falling 81 cycles after the first.
5. Reset mid-frame:
   - Stimulus: assert reset during d3 of 0x0F.
   - Required: next edge gives `txd`=1, `txd_busy`=0, no `txd_done`. A fresh send of 0x01 afterwards is bit-exact.
6. With `UART_TX_PARITY_EN`:
   - Stimulus: send 0x01, then 0x03.
   - Required: parity bits 1 and 0 respectively, each frame 88 cycles of `txd_busy`.
